// File: rtl/ex_pkg.sv
`default_nettype none
// ex_pkg: ALU codes, bubble instruction, multiplier sizing and FSM encoding for ex_stage.
// Rev 1.0
package ex_pkg;

  localparam int          MUL_CYCLES = 32;
  localparam int          CNT_W      = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0020;

  localparam logic [4:0] ALU_ADD   = 5'd0;
  localparam logic [4:0] ALU_SUB   = 5'd1;
  localparam logic [4:0] ALU_AND   = 5'd2;
  localparam logic [4:0] ALU_OR    = 5'd3;
  localparam logic [4:0] ALU_XOR   = 5'd4;
  localparam logic [4:0] ALU_NOR   = 5'd5;
  localparam logic [4:0] ALU_SLT   = 5'd6;
  localparam logic [4:0] ALU_SLTU  = 5'd7;
  localparam logic [4:0] ALU_SLL   = 5'd8;
  localparam logic [4:0] ALU_SRL   = 5'd9;
  localparam logic [4:0] ALU_SRA   = 5'd10;
  localparam logic [4:0] ALU_LUI   = 5'd11;
  localparam logic [4:0] ALU_MUL   = 5'd16;
  localparam logic [4:0] ALU_MULHU = 5'd17;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUSY = 2'd1,
    MS_DONE = 2'd2
  } mul_state_t;

  function automatic logic is_mul_code(input logic [4:0] code);
    return (code == ALU_MUL) || (code == ALU_MULHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ex_if.sv
`default_nettype none
// ex_if: ID/EX inputs, EX/MEM outputs and the upstream stall of the execute stage.
// Rev 1.0
interface ex_if;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_d2;
  logic [4:0]  ex_td;
  logic [4:0]  ex_Aluc;
  logic        ex_WREG;
  logic        ex_WMEM;
  logic        ex_LW;
  logic [31:0] ex_instr;
  logic        ex_stall;
  logic [31:0] mem_alu;
  logic [31:0] mem_d2;
  logic [4:0]  mem_td;
  logic        mem_WREG;
  logic        mem_WMEM;
  logic        mem_LW;
  logic [31:0] mem_instr;

  modport master (
    output ex_a, ex_b, ex_d2, ex_td, ex_Aluc, ex_WREG, ex_WMEM, ex_LW, ex_instr,
    input  ex_stall, mem_alu, mem_d2, mem_td, mem_WREG, mem_WMEM, mem_LW, mem_instr
  );

  modport slave (
    input  ex_a, ex_b, ex_d2, ex_td, ex_Aluc, ex_WREG, ex_WMEM, ex_LW, ex_instr,
    output ex_stall, mem_alu, mem_d2, mem_td, mem_WREG, mem_WMEM, mem_LW, mem_instr
  );
endinterface
`default_nettype wire

// File: rtl/ex_mul_seq.sv
`default_nettype none
// ex_mul_seq: shift-add unsigned 32x32 multiplier, one multiplier bit per BUSY cycle.
// Rev 1.0
module ex_mul_seq
  import ex_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        start,
  input  wire logic [31:0] a,
  input  wire logic [31:0] b,
  output logic             busy,
  output logic             done,
  output logic [63:0]      prod
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(MUL_CYCLES - 1);

  mul_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_mcand;
  logic [31:0]      r_mplier;
  logic [63:0]      r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= MS_IDLE;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else begin
      case (r_state)
        MS_IDLE: begin
          if (start) begin
            r_mcand  <= {32'h0, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= MS_BUSY;
          end
        end
        MS_BUSY: begin
          // Multiplicand walks left while the multiplier walks right, so bit 0 is always current.
          if (r_mplier[0]) begin
            r_acc <= r_acc + r_mcand;
          end
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + 1'b1;
          if (r_cnt == c_last) begin
            r_state <= MS_DONE;
          end
        end
        MS_DONE: begin
          r_state <= MS_IDLE;
        end
        default: begin
          r_state <= MS_IDLE;
        end
      endcase
    end
  end

  assign busy = (r_state == MS_BUSY);
  assign done = (r_state == MS_DONE);
  assign prod = r_acc;

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ex_stage: execute stage, inline ALU plus EX/MEM register; the sequential multiplier
// (MUL/MULHU, stalls upstream) is built only when EX_MUL_EN is defined.  Rev 1.0
module ex_stage
  import ex_pkg::*;
(
  input wire logic clk,
  input wire logic rst,
  ex_if.slave      bus
);

  logic [31:0] w_alu;
  logic [31:0] w_result;
  logic        w_stall;
  logic        w_bubble;

  always_comb begin
    w_alu = 32'h0;
    case (bus.ex_Aluc)
      ALU_ADD:  w_alu = bus.ex_a + bus.ex_b;
      ALU_SUB:  w_alu = bus.ex_a - bus.ex_b;
      ALU_AND:  w_alu = bus.ex_a & bus.ex_b;
      ALU_OR:   w_alu = bus.ex_a | bus.ex_b;
      ALU_XOR:  w_alu = bus.ex_a ^ bus.ex_b;
      ALU_NOR:  w_alu = ~(bus.ex_a | bus.ex_b);
      ALU_SLT:  w_alu = {31'h0, $signed(bus.ex_a) < $signed(bus.ex_b)};
      ALU_SLTU: w_alu = {31'h0, bus.ex_a < bus.ex_b};
      ALU_SLL:  w_alu = bus.ex_b << bus.ex_a[4:0];
      ALU_SRL:  w_alu = bus.ex_b >> bus.ex_a[4:0];
      ALU_SRA:  w_alu = $unsigned($signed(bus.ex_b) >>> bus.ex_a[4:0]);
      ALU_LUI:  w_alu = {bus.ex_b[15:0], 16'h0};
      default:  w_alu = 32'h0;
    endcase
  end

`ifdef EX_MUL_EN
  logic        w_is_mul;
  logic        w_start;
  logic        w_busy;
  logic        w_done;
  logic [63:0] w_prod;
  logic        r_mul_hi;

  assign w_is_mul = is_mul_code(bus.ex_Aluc);
  assign w_start  = w_is_mul & ~w_busy & ~w_done;
  assign w_stall  = w_start | w_busy;
  assign w_bubble = w_stall;

  ex_mul_seq u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .a     (bus.ex_a),
    .b     (bus.ex_b),
    .busy  (w_busy),
    .done  (w_done),
    .prod  (w_prod)
  );

  // Product half is chosen at start so later input wobble cannot flip it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_hi <= 1'b0;
    end else if (w_start) begin
      r_mul_hi <= (bus.ex_Aluc == ALU_MULHU);
    end
  end

  assign w_result = w_done ? (r_mul_hi ? w_prod[63:32] : w_prod[31:0]) : w_alu;
`else
  assign w_stall  = 1'b0;
  assign w_bubble = 1'b0;
  assign w_result = w_alu;
`endif

  logic [31:0] r_alu;
  logic [31:0] r_d2;
  logic [4:0]  r_td;
  logic        r_wreg;
  logic        r_wmem;
  logic        r_lw;
  logic [31:0] r_instr;

  always_ff @(posedge clk) begin
    if (rst || w_bubble) begin
      r_alu   <= 32'h0;
      r_d2    <= 32'h0;
      r_td    <= 5'h0;
      r_wreg  <= 1'b0;
      r_wmem  <= 1'b0;
      r_lw    <= 1'b0;
      r_instr <= NOP_INSTR;
    end else begin
      r_alu   <= w_result;
      r_d2    <= bus.ex_d2;
      r_td    <= bus.ex_td;
      r_wreg  <= bus.ex_WREG;
      r_wmem  <= bus.ex_WMEM;
      r_lw    <= bus.ex_LW;
      r_instr <= bus.ex_instr;
    end
  end

  assign bus.ex_stall  = w_stall;
  assign bus.mem_alu   = r_alu;
  assign bus.mem_d2    = r_d2;
  assign bus.mem_td    = r_td;
  assign bus.mem_WREG  = r_wreg;
  assign bus.mem_WMEM  = r_wmem;
  assign bus.mem_LW    = r_lw;
  assign bus.mem_instr = r_instr;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// tb_ex_stage: randomized and directed checks of ex_stage against an arithmetic reference model.
// Rev 1.0
module tb_ex_stage;
  import ex_pkg::*;

`ifdef EX_MUL_EN
  localparam bit c_mul_en = 1'b1;
`else
  localparam bit c_mul_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_if bus ();

  ex_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [4:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    longint unsigned p;
    longint signed   sa;
    longint signed   sb;
    p  = longint'(a) * longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return ~(a | b);
      5'd6:  return (sa < sb) ? 32'd1 : 32'd0;
      5'd7:  return (longint'(a) < longint'(b)) ? 32'd1 : 32'd0;
      5'd8:  return 32'(longint'(b) * (64'd1 << a[4:0]));
      5'd9:  return 32'(longint'(b) / (64'd1 << a[4:0]));
      5'd10: return 32'(sb >>> a[4:0]);
      5'd11: return {b[15:0], 16'h0};
      5'd16: return c_mul_en ? p[31:0] : 32'h0;
      5'd17: return c_mul_en ? p[63:32] : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] d2, input logic [4:0] td, input logic wreg,
                       input logic wmem, input logic lw, input logic [31:0] instr);
    bus.ex_Aluc  = code;
    bus.ex_a     = a;
    bus.ex_b     = b;
    bus.ex_d2    = d2;
    bus.ex_td    = td;
    bus.ex_WREG  = wreg;
    bus.ex_WMEM  = wmem;
    bus.ex_LW    = lw;
    bus.ex_instr = instr;
    #1;
  endtask

  // Single-cycle op already driven: no stall, everything lands in EX/MEM at the next edge.
  task automatic expect_single(input string tag);
    logic [31:0] e_alu;
    logic [31:0] e_d2;
    logic [31:0] e_instr;
    logic [4:0]  e_td;
    logic [2:0]  e_ctl;
    e_alu   = ref_alu(bus.ex_Aluc, bus.ex_a, bus.ex_b);
    e_d2    = bus.ex_d2;
    e_instr = bus.ex_instr;
    e_td    = bus.ex_td;
    e_ctl   = {bus.ex_WREG, bus.ex_WMEM, bus.ex_LW};
    check({tag, "/stall"}, bus.ex_stall, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "/alu"},   bus.mem_alu, e_alu);
    check({tag, "/d2"},    bus.mem_d2, e_d2);
    check({tag, "/td"},    bus.mem_td, e_td);
    check({tag, "/ctl"},   {bus.mem_WREG, bus.mem_WMEM, bus.mem_LW}, e_ctl);
    check({tag, "/instr"}, bus.mem_instr, e_instr);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "/alu"},   bus.mem_alu, 0);
    check({tag, "/d2"},    bus.mem_d2, 0);
    check({tag, "/td"},    bus.mem_td, 0);
    check({tag, "/ctl"},   {bus.mem_WREG, bus.mem_WMEM, bus.mem_LW}, 0);
    check({tag, "/instr"}, bus.mem_instr, 32'h20);
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input string tag, input logic [4:0] code, input logic [31:0] a,
                         input logic [31:0] b);
    longint unsigned p;
    logic [31:0]     e_alu;
    logic [31:0]     instr;
    logic [4:0]      td;
    int              n;
    bit              bad;
    p     = longint'(a) * longint'(b);
    e_alu = (code == 5'd17) ? p[63:32] : p[31:0];
    instr = $urandom;
    td    = 5'($urandom);
    drive(code, a, b, $urandom, td, 1'b1, 1'b0, 1'b0, instr);
    n   = 0;
    bad = 1'b0;
    while (bus.ex_stall && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.mem_WREG !== 1'b0 || bus.mem_instr !== 32'h20 || bus.mem_alu !== 32'h0)
        bad = 1'b1;
      bus.ex_a = $urandom;
      bus.ex_b = $urandom;
      #1;
    end
    check({tag, "/stall_cycles"}, n, 33);
    check({tag, "/bubbles"}, bad, 1'b0);
    @(posedge clk);
    #1;
    check({tag, "/alu"},   bus.mem_alu, e_alu);
    check({tag, "/td"},    bus.mem_td, td);
    check({tag, "/wreg"},  bus.mem_WREG, 1'b1);
    check({tag, "/instr"}, bus.mem_instr, instr);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] code;
    rst = 1'b1;
    drive(5'd0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset/stall", bus.ex_stall, 1'b0);
    check_cleared("reset");
    rst = 1'b0;

    drive(ALU_ADD, 5, 7, 32'h1234, 5'd3, 1'b1, 1'b0, 1'b0, 32'h00A3_1820);
    expect_single("add");
    drive(ALU_SLT, 32'hFFFF_FFFF, 1, 0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h1);
    expect_single("slt");
    check("slt/value", bus.mem_alu, 1);
    drive(ALU_SLTU, 32'hFFFF_FFFF, 1, 0, 5'd4, 1'b1, 1'b0, 1'b0, 32'h2);
    expect_single("sltu");
    check("sltu/value", bus.mem_alu, 0);
    drive(ALU_SRA, 4, 32'h8000_0000, 0, 5'd5, 1'b1, 1'b0, 1'b0, 32'h3);
    expect_single("sra");
    check("sra/value", bus.mem_alu, 32'hF800_0000);
    drive(ALU_SLL, 31, 1, 0, 5'd6, 1'b1, 1'b0, 1'b0, 32'h4);
    expect_single("sll");
    check("sll/value", bus.mem_alu, 32'h8000_0000);
    drive(ALU_LUI, 0, 32'h0000_BEEF, 0, 5'd7, 1'b1, 1'b0, 1'b1, 32'h5);
    expect_single("lui");

    for (int i = 0; i < 200; i++) begin
      code = 5'($urandom_range(0, 31));
      if (c_mul_en && is_mul_code(code)) code = ALU_SUB;
      drive(code, $urandom, $urandom, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), $urandom);
      expect_single($sformatf("rand%0d_op%0d", i, code));
    end

`ifdef EX_MUL_EN
    run_mul("mul", ALU_MUL, 32'h0000_FFFF, 32'h0001_0001);
    run_mul("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_mul("b2b_mul", ALU_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    for (int i = 0; i < 4; i++) begin
      run_mul($sformatf("rmul%0d", i), (i % 2 == 0) ? ALU_MUL : ALU_MULHU, $urandom, $urandom);
    end

    drive(ALU_MUL, 32'hDEAD_BEEF, 32'h0BAD_F00D, 32'h55, 5'd9, 1'b1, 1'b1, 1'b0, 32'h77);
    repeat (11) @(posedge clk);
    #1;
    check("abort/busy_stall", bus.ex_stall, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(ALU_ADD, 32'd100, 32'd23, 32'h9, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0017_1020);
    check("abort/stall", bus.ex_stall, 1'b0);
    check_cleared("abort");
    expect_single("abort_add");
    check("abort_add/value", bus.mem_alu, 123);
`else
    drive(ALU_MUL, 3, 4, 32'h42, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0064_4018);
    expect_single("mul_off");
    drive(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h43, 5'd9, 1'b1, 1'b1, 1'b1, 32'h99);
    expect_single("mulhu_off");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
